// File: rtl/sr04_tick_gen_cascade.sv
// rtl/sr04_tick_gen_cascade.sv - cascaded base / stage-1 / stage-2 tick generator
// Base divisor is runtime-programmable; stages ripple off the wrap of the stage below.
module sr04_tick_gen_cascade #(
  parameter int CLK_DIV = 100,
  parameter int S1_DIV  = 1000,
  parameter int S2_DIV  = 1000,
  parameter int DIV_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic             i_div_wr,
  input  logic [DIV_W-1:0] i_div_val,
  output logic             o_tick_base,
  output logic             o_tick_s1,
  output logic             o_tick_s2,
  output logic [DIV_W-1:0] o_div,
  output logic             o_div_err
);

  localparam int S1_W = (S1_DIV > 1) ? $clog2(S1_DIV) : 1;
  localparam int S2_W = (S2_DIV > 1) ? $clog2(S2_DIV) : 1;
  localparam logic [S1_W-1:0] S1_LAST = S1_W'(S1_DIV - 1);
  localparam logic [S2_W-1:0] S2_LAST = S2_W'(S2_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] base_cnt;
  logic [S1_W-1:0]  s1_cnt;
  logic [S2_W-1:0]  s2_cnt;

  logic div_val_ok;
  logic div_load;
  logic base_wrap;
  logic s1_wrap;
  logic s2_wrap;

  // A divisor load restarts the base phase, so it suppresses the wrap in that cycle.
  always_comb begin
    div_val_ok = (i_div_val >= DIV_W'(2));
    div_load   = i_div_wr && div_val_ok;
    base_wrap  = i_en && !i_clear && !div_load && (base_cnt == div_reg - DIV_W'(1));
    s1_wrap    = base_wrap && (s1_cnt == S1_LAST);
    s2_wrap    = s1_wrap && (s2_cnt == S2_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg     <= DIV_W'(CLK_DIV);
      base_cnt    <= '0;
      s1_cnt      <= '0;
      s2_cnt      <= '0;
      o_tick_base <= 1'b0;
      o_tick_s1   <= 1'b0;
      o_tick_s2   <= 1'b0;
      o_div_err   <= 1'b0;
    end else begin
      o_tick_base <= base_wrap;
      o_tick_s1   <= s1_wrap;
      o_tick_s2   <= s2_wrap;
      o_div_err   <= i_div_wr && !div_val_ok;
      if (div_load) begin
        div_reg <= i_div_val;
      end
      if (i_clear) begin
        base_cnt <= '0;
        s1_cnt   <= '0;
        s2_cnt   <= '0;
      end else if (div_load) begin
        base_cnt <= '0;
      end else if (i_en) begin
        base_cnt <= base_wrap ? '0 : base_cnt + DIV_W'(1);
        if (base_wrap) begin
          s1_cnt <= s1_wrap ? '0 : s1_cnt + S1_W'(1);
        end
        if (s1_wrap) begin
          s2_cnt <= s2_wrap ? '0 : s2_cnt + S2_W'(1);
        end
      end
    end
  end

  assign o_div = div_reg;

endmodule
